// File: rtl/audio_voice_mixer.sv
// ---------------------------------------------------------------------------
// audio_voice_mixer
//
// Mixes up to NVOICE sound-effect voices into one signed 16-bit sample for
// the codec driver. A frame request (sample_req[1]) presents the mix that
// was computed during the previous frame. The same request also launches a
// new mix. That mix walks the voices in order over a single shared
// sample-ROM read port and accumulates the returned samples. The result is
// saturated to 16 bits and parked in mix_buf until the next frame request.
//
// Ports:
//   clk           system clock (codec master clock domain)
//   reset         synchronous, active-high reset
//   play_start    per-voice start/restart pulse
//   play_base     per-voice start address, slice [i*ADDR_W +: ADDR_W]
//   play_len      per-voice length in samples, same slicing (0 = ignore)
//   voice_active  per-voice "currently playing" flag
//   sample_req    bit 1 = frame request, bit 0 = half-frame request (unused)
//   audio_output  signed PCM sample to the codec
//   rom_rd        sample-ROM read strobe, one cycle per read
//   rom_addr      sample-ROM word address, valid while rom_rd = 1
//   rom_data      signed sample, valid exactly ROM_LAT cycles after rom_rd
//   underrun      one-cycle pulse: frame request arrived while still mixing
// ---------------------------------------------------------------------------
module audio_voice_mixer #(
    parameter int NVOICE  = 4,
    parameter int ADDR_W  = 14,
    parameter int ROM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NVOICE-1:0]        play_start,
    input  logic [NVOICE*ADDR_W-1:0] play_base,
    input  logic [NVOICE*ADDR_W-1:0] play_len,
    output logic [NVOICE-1:0]        voice_active,
    input  logic [1:0]               sample_req,
    output logic [15:0]              audio_output,
    output logic                     rom_rd,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [15:0]              rom_data,
    output logic                     underrun
);

    // Enough headroom that summing NVOICE full-scale samples cannot wrap.
    localparam int ACC_W = 16 + $clog2(NVOICE);
    localparam int VW    = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    localparam logic [VW-1:0] LAST_V    = VW'(NVOICE - 1);
    localparam logic [2:0]    WAIT_LOAD = 3'(ROM_LAT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Per-voice views of the packed play_* buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] base_w   [NVOICE];
    logic [ADDR_W-1:0] len_w    [NVOICE];
    logic [NVOICE-1:0] start_ok;

    generate
        for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice_in
            assign base_w[gi]   = play_base[gi*ADDR_W +: ADDR_W];
            assign len_w[gi]    = play_len[gi*ADDR_W +: ADDR_W];
            // A zero-length start would leave a voice active with nothing to play.
            assign start_ok[gi] = play_start[gi] && (len_w[gi] != '0);
        end
    endgenerate

    // The codec drives both channels from the same mono sample, so the
    // half-frame request carries no work for the mixer.
    logic half_req_unused;
    assign half_req_unused = sample_req[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    state_q,    state_d;
    logic [VW-1:0]             v_q,        v_d;
    logic [2:0]                wait_q,     wait_d;
    logic signed [ACC_W-1:0]   acc_q,      acc_d;
    logic [15:0]               mix_q,      mix_d;
    logic [15:0]               audio_q,    audio_d;
    logic                      rom_rd_q,   rom_rd_d;
    logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
    logic                      underrun_q, underrun_d;
    logic [ADDR_W-1:0]         ptr_q [NVOICE];
    logic [ADDR_W-1:0]         ptr_d [NVOICE];
    logic [ADDR_W-1:0]         rem_q [NVOICE];
    logic [ADDR_W-1:0]         rem_d [NVOICE];
    logic [NVOICE-1:0]         active_q,   active_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        wait_d     = wait_q;
        acc_d      = acc_q;
        mix_d      = mix_q;
        audio_d    = audio_q;
        rom_rd_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        underrun_d = 1'b0;
        active_d   = active_q;
        for (int i = 0; i < NVOICE; i++) begin
            ptr_d[i] = ptr_q[i];
            rem_d[i] = rem_q[i];
        end

        // Every frame request presents mix_buf. If a mix is still running,
        // the codec gets the stale mix_buf and that mix carries on undisturbed.
        if (sample_req[1]) begin
            audio_d = mix_q;
            if (state_q != S_IDLE) begin
                underrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sample_req[1]) begin
                    state_d = S_FETCH;
                    v_d     = '0;
                end
            end

            S_FETCH: begin
                if (active_q[v_q]) begin
                    // The read strobe for this voice was issued on entry.
                    wait_d  = WAIT_LOAD;
                    state_d = (ROM_LAT > 1) ? S_WAIT : S_ACCUM;
                end else if (v_q == LAST_V) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = S_FETCH;
                end
            end

            S_WAIT: begin
                // Leaving on count 1 puts ACCUM exactly ROM_LAT cycles after FETCH.
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                acc_d        = acc_q + ACC_W'($signed(rom_data));
                ptr_d[v_q]   = ptr_q[v_q] + ADDR_W'(1);
                rem_d[v_q]   = rem_q[v_q] - ADDR_W'(1);
                if (rem_q[v_q] == ADDR_W'(1)) begin
                    active_d[v_q] = 1'b0;
                end
                if (v_q == LAST_V) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                if (acc_q > SAT_MAX) begin
                    mix_d = 16'h7FFF;
                end else if (acc_q < SAT_MIN) begin
                    mix_d = 16'h8000;
                end else begin
                    mix_d = acc_q[15:0];
                end
                acc_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A (re)start wins over the ACCUM pointer advance in the same cycle.
        for (int i = 0; i < NVOICE; i++) begin
            if (start_ok[i]) begin
                ptr_d[i]    = base_w[i];
                rem_d[i]    = len_w[i];
                active_d[i] = 1'b1;
            end
        end

        // The ROM strobe and address are registered, so they are decided
        // one cycle early from the state being entered. The FETCH cycle then
        // sees exactly the active flag and pointer used here. This is also
        // what lets a play_start coinciding with the frame request show up in
        // the first fetch.
        if ((state_d == S_FETCH) && active_d[v_d]) begin
            rom_rd_d   = 1'b1;
            rom_addr_d = ptr_d[v_d];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            v_q        <= '0;
            wait_q     <= '0;
            acc_q      <= '0;
            mix_q      <= '0;
            audio_q    <= '0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            underrun_q <= 1'b0;
            active_q   <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                ptr_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            wait_q     <= wait_d;
            acc_q      <= acc_d;
            mix_q      <= mix_d;
            audio_q    <= audio_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            underrun_q <= underrun_d;
            active_q   <= active_d;
            for (int i = 0; i < NVOICE; i++) begin
                ptr_q[i] <= ptr_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign voice_active = active_q;
    assign audio_output = audio_q;
    assign rom_rd       = rom_rd_q;
    assign rom_addr     = rom_addr_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_audio_voice_mixer
//
// Directed and randomized checks of audio_voice_mixer (NVOICE=4, ADDR_W=14,
// ROM_LAT=2). A ROM model answers reads after ROM_LAT cycles and returns
// 0xDEAD whenever no read is due. A frame-level reference model keeps
// per-voice pointer/remaining/active state. On each frame request it
// computes the whole mix at once with plain arithmetic and saturation.
// ---------------------------------------------------------------------------
module tb_audio_voice_mixer;

    localparam int NV = 4;
    localparam int AW = 14;
    localparam int RL = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NV-1:0]    play_start;
    logic [NV*AW-1:0] play_base;
    logic [NV*AW-1:0] play_len;
    logic [NV-1:0]    voice_active;
    logic [1:0]       sample_req;
    logic [15:0]      audio_output;
    logic             rom_rd;
    logic [AW-1:0]    rom_addr;
    logic [15:0]      rom_data = 16'hDEAD;
    logic             underrun;

    always #5 clk = ~clk;

    audio_voice_mixer #(.NVOICE(NV), .ADDR_W(AW), .ROM_LAT(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_start   (play_start),
        .play_base    (play_base),
        .play_len     (play_len),
        .voice_active (voice_active),
        .sample_req   (sample_req),
        .audio_output (audio_output),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .underrun     (underrun)
    );

    // Per-voice stimulus values packed onto the buses
    logic [AW-1:0] base_v [NV];
    logic [AW-1:0] len_v  [NV];

    always_comb begin
        play_base = '0;
        play_len  = '0;
        for (int i = 0; i < NV; i++) begin
            play_base[i*AW +: AW] = base_v[i];
            play_len[i*AW +: AW]  = len_v[i];
        end
    end

    // ROM model: data is valid exactly two cycles after the strobe cycle
    logic [15:0]   mem [0:16383];
    logic          req_v = 1'b0;
    logic [AW-1:0] req_a = '0;

    always @(posedge clk) begin
        req_v    <= rom_rd;
        req_a    <= rom_addr;
        rom_data <= req_v ? mem[req_a] : 16'hDEAD;
    end

    int cyc_cnt = 0;
    int rd_seen = 0;
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rom_rd === 1'b1) rd_seen <= rd_seen + 1;
    end

    // Reference model state
    logic [AW-1:0] m_ptr [NV];
    logic [AW-1:0] m_rem [NV];
    logic [NV-1:0] m_act;
    logic [15:0]   m_mix;
    logic [15:0]   last_out;
    int            exp_reads;
    int            t_req;
    int            rd_snap;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        m_act    = '0;
        m_mix    = '0;
        last_out = '0;
        for (int i = 0; i < NV; i++) begin
            m_ptr[i] = '0;
            m_rem[i] = '0;
        end
    endtask

    task automatic model_start(input int i);
        if (len_v[i] != '0) begin
            m_ptr[i] = base_v[i];
            m_rem[i] = len_v[i];
            m_act[i] = 1'b1;
        end
    endtask

    // One whole frame: return the previous mix, compute the new one.
    task automatic model_frame(output logic [15:0] out_prev);
        int s;
        s         = 0;
        exp_reads = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i]) begin
                s += int'($signed(mem[m_ptr[i]]));
                exp_reads++;
                m_ptr[i] = m_ptr[i] + 1'b1;
                m_rem[i] = m_rem[i] - 1'b1;
                if (m_rem[i] == '0) m_act[i] = 1'b0;
            end
        end
        out_prev = m_mix;
        if (s > 32767)       m_mix = 16'h7FFF;
        else if (s < -32768) m_mix = 16'h8000;
        else                 m_mix = s[15:0];
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        play_start = '0;
        sample_req = '0;
        cyc(2);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic quiet_start(input logic [NV-1:0] mask);
        play_start = mask;
        for (int i = 0; i < NV; i++) if (mask[i]) model_start(i);
        cyc(1);
        play_start = '0;
    endtask

    // Issue a frame request (optionally with same-cycle starts); leaves the
    // bench in the cycle right after the request.
    task automatic frame_begin(input logic [NV-1:0] same_mask);
        for (int i = 0; i < NV; i++) if (same_mask[i]) model_start(i);
        model_frame(last_out);
        play_start = same_mask;
        sample_req = 2'b10;
        rd_snap    = rd_seen;
        t_req      = cyc_cnt;
        cyc(1);
        play_start = '0;
        sample_req = '0;
        check("frame_out", audio_output, last_out);
        check("no_underrun", underrun, 1'b0);
    endtask

    task automatic frame_end(input int span);
        while (cyc_cnt < t_req + span) cyc(1);
        check("frame_reads", rd_seen - rd_snap, exp_reads);
        check("voice_active", voice_active, m_act);
    endtask

    task automatic fill_identity();
        for (int a = 0; a < 16384; a++) mem[a] = 16'(a);
    endtask

    task automatic fill_const(input logic [15:0] val);
        for (int a = 0; a < 16384; a++) mem[a] = val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] seq [5];
    logic [15:0] prev_out;
    logic [NV-1:0] mask;

    initial begin
        reset      = 1'b1;
        play_start = '0;
        sample_req = '0;
        for (int i = 0; i < NV; i++) begin
            base_v[i] = '0;
            len_v[i]  = '0;
        end
        fill_identity();
        model_clear();

        // Reset state
        cyc(3);
        check("rst_audio", audio_output, 16'h0000);
        check("rst_active", voice_active, 4'h0);
        check("rst_rom_rd", rom_rd, 1'b0);
        check("rst_rom_addr", rom_addr, 14'h0);
        check("rst_underrun", underrun, 1'b0);
        reset = 1'b0;

        // Idle frames: silence, no ROM traffic
        repeat (3) begin
            frame_begin('0);
            check("idle_silence", audio_output, 16'h0000);
            frame_end(256);
        end

        // Single voice 0: base 0x100, length 3, identity ROM
        seq[0] = 16'h0000; seq[1] = 16'h0100; seq[2] = 16'h0101;
        seq[3] = 16'h0102; seq[4] = 16'h0000;
        base_v[0] = 14'h100;
        len_v[0]  = 14'd3;
        quiet_start(4'b0001);
        for (int k = 0; k < 5; k++) begin
            frame_begin('0);
            check("v0_seq", audio_output, seq[k]);
            if (k == 0) begin
                check("v0_rd_t1", rom_rd, 1'b1);
                check("v0_addr_t1", rom_addr, 14'h100);
                cyc(1);
                check("v0_rd_t2", rom_rd, 1'b0);
            end
            if (k == 2) begin
                cyc(2);
                check("v0_active_accum", voice_active[0], 1'b1);
                cyc(1);
                check("v0_active_fall", voice_active[0], 1'b0);
            end
            frame_end(40);
        end

        // Saturation: all four voices at +0x7000, then -0x7000 (0x9000)
        for (int i = 0; i < NV; i++) begin
            base_v[i] = AW'($urandom);
            len_v[i]  = 14'd1;
        end
        fill_const(16'h7000);
        quiet_start(4'hF);
        frame_begin('0);
        frame_end(40);
        fill_const(16'h9000);
        quiet_start(4'hF);
        frame_begin('0);
        check("sat_pos", audio_output, 16'h7FFF);
        frame_end(40);
        base_v[0] = 14'h0010; mem[14'h0010] = 16'h1000;
        base_v[1] = 14'h0020; mem[14'h0020] = 16'h0200;
        base_v[2] = 14'h0030; mem[14'h0030] = 16'hFFF0;
        base_v[3] = 14'h0040; mem[14'h0040] = 16'h0000;
        quiet_start(4'hF);
        frame_begin('0);
        check("sat_neg", audio_output, 16'h8000);
        frame_end(40);
        frame_begin('0);
        check("mixed_sum", audio_output, 16'h11F0);
        frame_end(40);

        // Same-cycle start of voice 1, then restart during its ACCUM
        do_reset();
        fill_identity();
        base_v[1] = 14'h300;
        len_v[1]  = 14'd5;
        frame_begin(4'b0010);
        cyc(1);
        check("same_cycle_rd", rom_rd, 1'b1);
        check("same_cycle_addr", rom_addr, 14'h300);
        cyc(2);
        base_v[1] = 14'h200;
        len_v[1]  = 14'd2;
        play_start = 4'b0010;
        model_start(1);
        cyc(1);
        play_start = '0;
        frame_end(40);
        frame_begin('0);
        check("restart_out", audio_output, 16'h0300);
        cyc(1);
        check("restart_rd", rom_rd, 1'b1);
        check("restart_addr", rom_addr, 14'h200);
        frame_end(40);
        frame_begin('0);
        check("restart_out2", audio_output, 16'h0200);
        frame_end(40);
        frame_begin('0);
        check("restart_out3", audio_output, 16'h0201);
        frame_end(40);

        // Underrun: second request 5 cycles after the first
        for (int i = 0; i < NV; i++) begin
            base_v[i] = AW'(14'h400 + i * 14'h40);
            len_v[i]  = 14'd4;
        end
        quiet_start(4'hF);
        frame_begin('0);
        frame_end(40);
        frame_begin('0);
        prev_out = last_out;
        cyc(4);
        sample_req = 2'b10;
        cyc(1);
        sample_req = '0;
        check("underrun_pulse", underrun, 1'b1);
        check("underrun_hold", audio_output, prev_out);
        cyc(1);
        check("underrun_clear", underrun, 1'b0);
        frame_end(40);
        frame_begin('0);
        frame_end(40);

        // Reset during the WAIT of voice 2
        for (int i = 0; i < NV; i++) begin
            base_v[i] = AW'(14'h800 + i * 14'h10);
            len_v[i]  = 14'd8;
        end
        quiet_start(4'hF);
        frame_begin('0);
        cyc(7);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        model_clear();
        check("midrst_audio", audio_output, 16'h0000);
        check("midrst_active", voice_active, 4'h0);
        check("midrst_rom_rd", rom_rd, 1'b0);
        check("midrst_rom_addr", rom_addr, 14'h0);
        check("midrst_underrun", underrun, 1'b0);
        base_v[0] = 14'h123;
        len_v[0]  = 14'd1;
        quiet_start(4'b0001);
        frame_begin('0);
        frame_end(40);
        frame_begin('0);
        check("midrst_clean_acc", audio_output, 16'h0123);
        frame_end(40);

        // Randomized frames against the reference model
        for (int a = 0; a < 16384; a++) mem[a] = 16'($urandom);
        for (int f = 0; f < 40; f++) begin
            mask = '0;
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    base_v[i] = AW'($urandom);
                    len_v[i]  = AW'($urandom_range(0, 4));
                    mask[i]   = 1'b1;
                end
            end
            quiet_start(mask);
            if ($urandom_range(0, 1) == 1) begin
                sample_req = 2'b01;
                cyc(1);
                sample_req = '0;
                check("half_req_hold", audio_output, last_out);
            end
            cyc($urandom_range(0, 5));
            mask = '0;
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    base_v[i] = AW'($urandom);
                    len_v[i]  = AW'($urandom_range(0, 3));
                    mask[i]   = 1'b1;
                end
            end
            frame_begin(mask);
            frame_end(40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_voice_mixer.md
Name: audio_voice_mixer

Overview:
- Mixes up to NVOICE sound-effect voices into the single 16-bit sample stream consumed by the SSM2603 codec driver.
- Sequences reads of per-voice PCM samples over one shared sample-ROM read port and sums them with saturation.
- Prepares the next mixed sample ahead of time, so audio_output is stable on the cycle after the codec's sample_req[1] pulse.

Parameters:
- NVOICE, 4, number of independent voices (1..8).
- ADDR_W, 14, sample-ROM word address width.
- ROM_LAT, 2, cycles from rom_rd assertion to valid rom_data (1..4).

Ports:
- clk  in  1  system clock (codec master clock domain).
- reset  in  1  synchronous, active-high reset.
- play_start  in  NVOICE  one-cycle pulse per voice: start or restart playback.
- play_base  in  NVOICE*ADDR_W  per-voice start address; voice i uses slice [i*ADDR_W +: ADDR_W]; sampled on play_start.
- play_len  in  NVOICE*ADDR_W  per-voice length in samples; same slicing; sampled on play_start.
- voice_active  out  NVOICE  voice i currently playing.
- sample_req  in  2  codec request pulses; bit 1 = frame request, bit 0 = half-frame request.
- audio_output  out  16  signed PCM sample to the codec.
- rom_rd  out  1  sample-ROM read strobe, one cycle per read.
- rom_addr  out  ADDR_W  sample-ROM address, valid while rom_rd=1.
- rom_data  in  16  signed sample, valid exactly ROM_LAT cycles after rom_rd.
- underrun  out  1  one-cycle pulse: sample_req[1] arrived while a mix was still in progress.

Behaviour:
- Reset values: audio_output=0, mix_buf=0, acc=0, voice_active=0, rom_rd=0, rom_addr=0, underrun=0, FSM=IDLE.
- Per-voice state: ptr (ADDR_W), remaining (ADDR_W), active.
- play_start[i] with play_len slice != 0 → ptr=base, remaining=len, active=1.
  - Restart mid-play is allowed and overrides any pointer update in the same cycle.
  - play_start[i] with length 0 is ignored.
- sample_req[1] at cycle T:
  - audio_output<=mix_buf.
  - If FSM=IDLE, FSM→FETCH with v=0 at T+1.
  - play_start in cycle T is visible to that fetch.
- sample_req[0]: no action; audio_output holds (mono, both channels identical).
- FSM states: IDLE, FETCH, WAIT, ACCUM, DONE.
- FETCH(v), voice active: rom_rd=1, rom_addr=ptr[v]; wait counter loads ROM_LAT-1; →WAIT.
- FETCH(v), voice inactive: no read, contributes 0; v++ or →DONE after the last voice. Costs 1 cycle.
- WAIT: count down; →ACCUM when counter reaches 0. ACCUM therefore falls exactly ROM_LAT cycles after FETCH.
- ACCUM:
  - acc += sign-extended rom_data; acc width is 16+clog2(NVOICE), signed.
  - ptr[v]++ and remaining[v]--; if remaining hits 0, active[v]<=0 in the same cycle.
  - v++ → FETCH, or → DONE after the last voice.
- DONE:
  - mix_buf <= acc saturated to 16 bits: >32767 → 0x7FFF, <-32768 → 0x8000.
  - acc<=0; →IDLE.
- Latency (ROM_LAT=2, 4 active voices):
  - ACCUM at T+3, T+6, T+9, T+12; DONE at T+13.
  - mix_buf is valid from T+14 and is output at the next sample_req[1].
  - Worst case is well inside the 256-cycle frame.
- Pipeline: each frame outputs the mix computed in the previous frame (one-frame latency). The first frame after reset outputs 0.
- Underrun: sample_req[1] while FSM!=IDLE → underrun=1 for one cycle, audio_output<=mix_buf (stale value), in-progress mix continues, no new fetch is launched.
- ptr wraps modulo 2^ADDR_W. No bounds check beyond remaining.
- Reset mid-fetch: everything returns to reset values next cycle; outstanding ROM data is ignored.

Test Plan:
- Reset, then 3 sample_req[1] pulses 256 cycles apart with no play_start → audio_output=0 throughout, rom_rd never asserted.
- ROM model rom_data={2'b0,addr}; voice 0 base 0x100, len 3; sample_req[1] every 256 cycles:
  - audio_output sequence 0, 0x0100, 0x0101, 0x0102, 0.
  - voice_active[0] falls at the ACCUM of address 0x102.
  - rom_rd appears at T+1, rom_data is accumulated at T+3.
- All 4 voices active with ROM constant 0x7000 → audio_output=0x7FFF.
  - ROM constant 0x9000 → 0x8000.
  - Voices returning 0x1000, 0x0200, 0xFFF0, 0x0000 → 0x11F0.
- play_start[1] in the same cycle as sample_req[1] → that frame's fetch reads voice 1 at base.
  - Restart voice 1 mid-play with a new base 0x200 → next read address is 0x200, remaining reloaded.
- Two sample_req[1] pulses 5 cycles apart with 4 active voices → underrun pulse on the second request, audio_output holds the previous mix_buf, mix completes normally.
- Assert reset during WAIT of voice 2 → next cycle all outputs are at reset values; a late rom_data arrival does not alter acc.
